mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
- Two-requester arbiter that sits directly upstream of the single-port synchronous RAM (`mem`).
- Merges the instruction-fetch port (read-only) and the load/store port (read/write) onto the RAM's single address, write-enable and write-data bus.
- Tracks the RAM's 1-cycle read latency and routes each returned word back to the requester that issued the read, qualified by a one-cycle valid pulse.

Parameters:
- P_IF_PRIO, 0: fixed-priority winner when both ports request. 0 = load/store wins; 1 = fetch wins. Ignored when MEM_ARB_RR_EN is defined.

Ports:
- iw_clk  in  1  clock; all logic on the rising edge.
- iw_rst  in  1  synchronous, active-high reset.
- iw_if_req  in  1  fetch read request; held until granted.
- iw_if_addr  in  HBIT_ADDR+1  fetch word address.
- ow_if_gnt  out  1  combinational; fetch request accepted this cycle.
- or_if_rvalid  out  1  fetch read data valid, one-cycle pulse.
- or_if_rdata  out  HBIT_DATA+1  fetch read data.
- iw_ls_req  in  1  load/store request; held until granted.
- iw_ls_we  in  1  1 = store, 0 = load.
- iw_ls_addr  in  HBIT_ADDR+1  load/store word address.
- iw_ls_wdata  in  HBIT_DATA+1  store data.
- ow_ls_gnt  out  1  combinational; load/store request accepted this cycle.
- or_ls_rvalid  out  1  load data valid, one-cycle pulse; never asserted for stores.
- or_ls_rdata  out  HBIT_DATA+1  load data.
- ow_mem_we  out  1  RAM write enable.
- ow_mem_addr  out  HBIT_ADDR+1  RAM address.
- ow_mem_wdata  out  HBIT_DATA+1  RAM write data.
- iw_mem_rdata  in  HBIT_DATA+1  RAM registered read data, valid one cycle after the address is presented.

Behaviour:
- Clock is iw_clk. Reset iw_rst is synchronous and active-high.
- Reset values:
  - or_if_rvalid = 0, or_ls_rvalid = 0.
  - or_if_rdata = 0, or_ls_rdata = 0.
  - Response pipeline owner tags = OWN_NONE.
  - Round-robin pointer = fetch-next.
- While iw_rst is high: ow_if_gnt = 0, ow_ls_gnt = 0, ow_mem_we = 0.
- Grant rules:
  - At most one grant per cycle.
  - Grant is combinational from the requests and the priority state.
  - A requester must hold req, addr, we and wdata stable until its gnt is seen high.
- Memory drive:
  - In the grant cycle, ow_mem_addr = winner address.
  - ow_mem_we = winner's we; always 0 for fetch.
  - ow_mem_wdata = iw_ls_wdata.
- Idle cycle (no grant):
  - ow_mem_we = 0.
  - ow_mem_addr holds the last granted address, so the RAM performs only a harmless read.
- Read latency:
  - Read granted in cycle T: address presented in T, iw_mem_rdata valid in T+1.
  - Arbiter registers the data into or_*_rdata with or_*_rvalid = 1 in T+2.
  - Fixed latency of 2 cycles from grant to rvalid.
- Owner tracking:
  - 2-stage tag pipeline with encodings OWN_NONE / OWN_IF / OWN_LS.
  - A store inserts OWN_NONE.
- Back-to-back:
  - One grant per cycle sustained; reads issued on consecutive cycles return on consecutive cycles.
  - The two ports may receive rvalid on adjacent cycles but never in the same cycle.
- rdata registers hold their last value when rvalid = 0.
- RAM is read-first:
  - A store in T followed by a load or fetch of the same address in T+1 returns the new data.
- Reset mid-operation: in-flight tags are cleared; no rvalid is produced for reads granted before reset.
- Starvation: with fixed priority and continuous high-priority requests, the low-priority port may starve. This is accepted in the fixed-priority mode only.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - When both ports request, the port not granted most recently wins.
  - The pointer updates only on cycles where a grant is issued.
  - P_IF_PRIO is ignored.
- MEM_ARB_RR_EN undefined: fixed priority per P_IF_PRIO; no pointer register is present.

Decomposition:
- Shared header: owner tag width and constants OWN_NONE=2'd0, OWN_IF=2'd1, OWN_LS=2'd2. HBIT_ADDR and HBIT_DATA continue to come from the shared sizes header.
- One natural sub-module: mem_arb_pick, containing the combinational grant selection plus the round-robin pointer.
- Tag pipeline and response registers stay in mem_arb.

Test Plan:
- Single fetch: if_req=1, if_addr=0x010, RAM[0x010]=0xABCDEF, grant T -> if_rvalid=1, if_rdata=0xABCDEF at T+2; ls_rvalid stays 0.
- Store then load: ls store addr 0x020 wdata 0x123456 at T, ls load 0x020 at T+1 -> ls_rvalid at T+3 with 0x123456; no rvalid for the store.
- Contention, fixed priority P_IF_PRIO=0: both request in T -> ls_gnt at T, if_gnt at T+1; rvalids arrive in order ls at T+2, if at T+3.
- Contention with MEM_ARB_RR_EN: both requesting continuously for 6 cycles -> grants alternate IF, LS, IF, LS, IF, LS starting from IF after reset.
- Reset mid-flight: fetch granted at T, iw_rst=1 at T+1 -> no if_rvalid at T+2; all outputs at reset values.
- Streaming: fetch reads 0x000..0x007 granted on 8 consecutive cycles -> if_rvalid high for 8 consecutive cycles with data in address order.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the two-port RAM arbiter: address/data widths
// and the owner tags that follow each read through the RAM latency.
package mem_arb_pkg;

   localparam int HBIT_ADDR = 9;
   localparam int HBIT_DATA = 23;

   localparam int OWN_W = 2;
   typedef enum logic [OWN_W-1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_LS   = 2'd2
   } own_t;

   // Number of cycles a tag travels: one for the RAM, one for the response register.
   localparam int TAG_STAGES = 2;

   function automatic own_t own_of(input logic if_gnt, input logic ls_gnt, input logic ls_we);
      own_t t;
      t = OWN_NONE;
      if (if_gnt)
         t = OWN_IF;
      else if (ls_gnt && !ls_we)
         t = OWN_LS;
      return t;
   endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the RAM.
// The arbiter connects through the slave modport; the environment uses master.
interface mem_arb_if;
   import mem_arb_pkg::*;

   logic                 iw_if_req;
   logic [HBIT_ADDR:0]   iw_if_addr;
   logic                 ow_if_gnt;
   logic                 or_if_rvalid;
   logic [HBIT_DATA:0]   or_if_rdata;

   logic                 iw_ls_req;
   logic                 iw_ls_we;
   logic [HBIT_ADDR:0]   iw_ls_addr;
   logic [HBIT_DATA:0]   iw_ls_wdata;
   logic                 ow_ls_gnt;
   logic                 or_ls_rvalid;
   logic [HBIT_DATA:0]   or_ls_rdata;

   logic                 ow_mem_we;
   logic [HBIT_ADDR:0]   ow_mem_addr;
   logic [HBIT_DATA:0]   ow_mem_wdata;
   logic [HBIT_DATA:0]   iw_mem_rdata;

   modport slave (
      input  iw_if_req, iw_if_addr, iw_ls_req, iw_ls_we, iw_ls_addr, iw_ls_wdata, iw_mem_rdata,
      output ow_if_gnt, or_if_rvalid, or_if_rdata, ow_ls_gnt, or_ls_rvalid, or_ls_rdata,
             ow_mem_we, ow_mem_addr, ow_mem_wdata
   );

   modport master (
      output iw_if_req, iw_if_addr, iw_ls_req, iw_ls_we, iw_ls_addr, iw_ls_wdata, iw_mem_rdata,
      input  ow_if_gnt, or_if_rvalid, or_if_rdata, ow_ls_gnt, or_ls_rvalid, or_ls_rdata,
             ow_mem_we, ow_mem_addr, ow_mem_wdata
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch and load/store.
// MEM_ARB_RR_EN selects round-robin with a one-bit pointer; otherwise fixed priority.
module mem_arb_pick #(
   parameter int P_IF_PRIO = 0
) (
`ifdef MEM_ARB_RR_EN
   input  logic clk,
`endif
   input  logic rst,
   input  logic if_req,
   input  logic ls_req,
   output logic if_gnt,
   output logic ls_gnt
);

   logic if_first;

`ifdef MEM_ARB_RR_EN
   // ptr_reg = 1 means fetch wins the next contended cycle.
   logic ptr_reg;
   logic ptr_next;

   always_ff @(posedge clk) begin
      if (rst)
         ptr_reg <= 1'b1;
      else
         ptr_reg <= ptr_next;
   end

   always_comb begin
      ptr_next = ptr_reg;
      if (if_gnt)
         ptr_next = 1'b0;
      else if (ls_gnt)
         ptr_next = 1'b1;
   end

   assign if_first = ptr_reg;
`else
   assign if_first = (P_IF_PRIO != 0);
`endif

   always_comb begin
      if_gnt = 1'b0;
      ls_gnt = 1'b0;
      if (!rst) begin
         if (if_req && (!ls_req || if_first))
            if_gnt = 1'b1;
         else if (ls_req)
            ls_gnt = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arb.sv
// Two-requester arbiter in front of a single-port, 1-cycle-latency RAM.
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int P_IF_PRIO = 0
) (
   input logic       iw_clk,
   input logic       iw_rst,
   mem_arb_if.slave  bus
);

   logic               if_gnt;
   logic               ls_gnt;
   logic [HBIT_ADDR:0] mem_addr;
   logic [HBIT_ADDR:0] last_addr_reg;
   own_t               tag_reg [TAG_STAGES];
   own_t               tag_next;
   logic [HBIT_DATA:0] if_rdata_reg;
   logic [HBIT_DATA:0] ls_rdata_reg;

   mem_arb_pick #(
      .P_IF_PRIO (P_IF_PRIO)
   ) u_pick (
`ifdef MEM_ARB_RR_EN
      .clk    (iw_clk),
`endif
      .rst    (iw_rst),
      .if_req (bus.iw_if_req),
      .ls_req (bus.iw_ls_req),
      .if_gnt (if_gnt),
      .ls_gnt (ls_gnt)
   );

   // Idle cycles re-present the last address so the RAM only does a harmless read.
   always_comb begin
      mem_addr = last_addr_reg;
      if (if_gnt)
         mem_addr = bus.iw_if_addr;
      else if (ls_gnt)
         mem_addr = bus.iw_ls_addr;
   end

   assign tag_next = own_of(if_gnt, ls_gnt, bus.iw_ls_we);

   always_ff @(posedge iw_clk) begin
      if (iw_rst) begin
         last_addr_reg <= '0;
         if_rdata_reg  <= '0;
         ls_rdata_reg  <= '0;
         for (int i = 0; i < TAG_STAGES; i++)
            tag_reg[i] <= OWN_NONE;
      end else begin
         if (if_gnt || ls_gnt)
            last_addr_reg <= mem_addr;
         tag_reg[0] <= tag_next;
         for (int i = 1; i < TAG_STAGES; i++)
            tag_reg[i] <= tag_reg[i-1];
         // Stage 0 marks the cycle the RAM data for that read is on iw_mem_rdata.
         if (tag_reg[0] == OWN_IF)
            if_rdata_reg <= bus.iw_mem_rdata;
         if (tag_reg[0] == OWN_LS)
            ls_rdata_reg <= bus.iw_mem_rdata;
      end
   end

   assign bus.ow_if_gnt    = if_gnt;
   assign bus.ow_ls_gnt    = ls_gnt;
   assign bus.ow_mem_addr  = mem_addr;
   assign bus.ow_mem_we    = ls_gnt & bus.iw_ls_we;
   assign bus.ow_mem_wdata = bus.iw_ls_wdata;
   assign bus.or_if_rvalid = (tag_reg[TAG_STAGES-1] == OWN_IF);
   assign bus.or_ls_rvalid = (tag_reg[TAG_STAGES-1] == OWN_LS);
   assign bus.or_if_rdata  = if_rdata_reg;
   assign bus.or_ls_rdata  = ls_rdata_reg;

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: a RAM model, a reference memory and a grant model.
// Build with MEM_ARB_RR_EN defined to exercise the round-robin variant.
module tb_mem_arb;
   import mem_arb_pkg::*;

   localparam int IF_PRIO = 0;

   typedef struct {
      logic [HBIT_DATA:0] data;
      int                 cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;

   mem_arb_if bus();

   mem_arb #(
      .P_IF_PRIO (IF_PRIO)
   ) dut (
      .iw_clk (clk),
      .iw_rst (rst),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [HBIT_DATA:0] init_val(input int a);
      if (a == 'h010)
         return 24'hABCDEF;
      return 24'(a * 24'h010203) ^ 24'h5A5A5A;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // RAM model: registered, read-first.
   logic [HBIT_DATA:0] ram [1024];
   logic               ram_loaded = 1'b0;
   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < 1024; i++)
            ram[i] <= init_val(i);
         ram_loaded <= 1'b1;
      end else begin
         if (bus.ow_mem_we)
            ram[bus.ow_mem_addr] <= bus.ow_mem_wdata;
         bus.iw_mem_rdata <= ram[bus.ow_mem_addr];
      end
   end

   // Monitor + scoreboard
   logic [HBIT_DATA:0] ref_mem [1024];
   logic               ref_loaded = 1'b0;
   exp_t               q_if[$];
   exp_t               q_ls[$];
   bit                 rr_if_next = 1'b1;
   logic [HBIT_ADDR:0] last_addr = '0;
   bit                 last_known = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      bit   if_first;
      bit   exp_if;
      bit   exp_ls;
      cyc++;
      if (!ref_loaded) begin
         for (int i = 0; i < 1024; i++)
            ref_mem[i] = init_val(i);
         ref_loaded = 1'b1;
      end
      check("rvalid_excl", 32'(bus.or_if_rvalid & bus.or_ls_rvalid), 0);
      if (bus.or_if_rvalid) begin
         if (q_if.size() == 0) begin
            check("if_spurious_rvalid", 1, 0);
         end else begin
            e = q_if.pop_front();
            $display("IF  read  data=%06h expected=%06h cycle=%0d", bus.or_if_rdata, e.data, cyc);
            check("if_rdata", 32'(bus.or_if_rdata), 32'(e.data));
            check("if_latency", cyc, e.cyc);
         end
      end
      if (bus.or_ls_rvalid) begin
         if (q_ls.size() == 0) begin
            check("ls_spurious_rvalid", 1, 0);
         end else begin
            e = q_ls.pop_front();
            $display("LS  load  data=%06h expected=%06h cycle=%0d", bus.or_ls_rdata, e.data, cyc);
            check("ls_rdata", 32'(bus.or_ls_rdata), 32'(e.data));
            check("ls_latency", cyc, e.cyc);
         end
      end
      if (rst) begin
         q_if.delete();
         q_ls.delete();
         rr_if_next = 1'b1;
         last_known = 1'b0;
         check("rst_if_gnt", 32'(bus.ow_if_gnt), 0);
         check("rst_ls_gnt", 32'(bus.ow_ls_gnt), 0);
         check("rst_mem_we", 32'(bus.ow_mem_we), 0);
      end else begin
`ifdef MEM_ARB_RR_EN
         if_first = rr_if_next;
`else
         if_first = (IF_PRIO != 0);
`endif
         exp_if = bus.iw_if_req && (!bus.iw_ls_req || if_first);
         exp_ls = bus.iw_ls_req && !exp_if;
         check("if_gnt", 32'(bus.ow_if_gnt), 32'(exp_if));
         check("ls_gnt", 32'(bus.ow_ls_gnt), 32'(exp_ls));
         if (bus.ow_if_gnt) begin
            check("if_mem_addr", 32'(bus.ow_mem_addr), 32'(bus.iw_if_addr));
            check("if_mem_we", 32'(bus.ow_mem_we), 0);
            q_if.push_back('{ref_mem[bus.iw_if_addr], cyc + 2});
            last_addr = bus.iw_if_addr;
            last_known = 1'b1;
            rr_if_next = 1'b0;
         end else if (bus.ow_ls_gnt) begin
            check("ls_mem_addr", 32'(bus.ow_mem_addr), 32'(bus.iw_ls_addr));
            check("ls_mem_we", 32'(bus.ow_mem_we), 32'(bus.iw_ls_we));
            if (bus.iw_ls_we) begin
               check("ls_mem_wdata", 32'(bus.ow_mem_wdata), 32'(bus.iw_ls_wdata));
               ref_mem[bus.iw_ls_addr] = bus.iw_ls_wdata;
               $display("LS  store addr=%03h data=%06h cycle=%0d", bus.iw_ls_addr, bus.iw_ls_wdata, cyc);
            end else begin
               q_ls.push_back('{ref_mem[bus.iw_ls_addr], cyc + 2});
            end
            last_addr = bus.iw_ls_addr;
            last_known = 1'b1;
            rr_if_next = 1'b1;
         end else begin
            check("idle_mem_we", 32'(bus.ow_mem_we), 0);
            if (last_known)
               check("idle_mem_addr", 32'(bus.ow_mem_addr), 32'(last_addr));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Issue n_if fetches and n_ls loads at incrementing addresses; each request held until granted.
   task automatic run_ports(input int n_if, input int if_base, input int n_ls, input int ls_base);
      int   if_left;
      int   ls_left;
      int   guard;
      logic g_if;
      logic g_ls;
      if_left = n_if;
      ls_left = n_ls;
      guard = 0;
      bus.iw_if_req  = (n_if > 0);
      bus.iw_if_addr = (HBIT_ADDR+1)'(if_base);
      bus.iw_ls_req  = (n_ls > 0);
      bus.iw_ls_we   = 1'b0;
      bus.iw_ls_addr = (HBIT_ADDR+1)'(ls_base);
      while ((if_left > 0 || ls_left > 0) && guard < 64) begin
         @(negedge clk);
         g_if = bus.ow_if_gnt;
         g_ls = bus.ow_ls_gnt;
         step(1);
         guard++;
         if (g_if) begin
            if_left--;
            bus.iw_if_addr = bus.iw_if_addr + 1'b1;
            bus.iw_if_req  = (if_left > 0);
         end
         if (g_ls) begin
            ls_left--;
            bus.iw_ls_addr = bus.iw_ls_addr + 1'b1;
            bus.iw_ls_req  = (ls_left > 0);
         end
      end
      if (guard >= 64)
         check("run_ports_timeout", 1, 0);
      bus.iw_if_req = 1'b0;
      bus.iw_ls_req = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_if_rvalid"}, 32'(bus.or_if_rvalid), 0);
      check({tag, "_ls_rvalid"}, 32'(bus.or_ls_rvalid), 0);
      check({tag, "_if_rdata"}, 32'(bus.or_if_rdata), 0);
      check({tag, "_ls_rdata"}, 32'(bus.or_ls_rdata), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.iw_if_req   = 1'b0;
      bus.iw_if_addr  = '0;
      bus.iw_ls_req   = 1'b0;
      bus.iw_ls_we    = 1'b0;
      bus.iw_ls_addr  = '0;
      bus.iw_ls_wdata = '0;
      rst = 1'b1;
      step(2);
      // Requests during reset must not be granted.
      bus.iw_if_req = 1'b1;
      bus.iw_ls_req = 1'b1;
      bus.iw_ls_we  = 1'b1;
      step(1);
      bus.iw_if_req = 1'b0;
      bus.iw_ls_req = 1'b0;
      bus.iw_ls_we  = 1'b0;
      step(1);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");
      step(1);

      // Single fetch of 0x010.
      run_ports(1, 'h010, 0, 0);
      step(4);

      // Store 0x123456 to 0x020, then load it back on the next cycle.
      bus.iw_ls_req   = 1'b1;
      bus.iw_ls_we    = 1'b1;
      bus.iw_ls_addr  = 10'h020;
      bus.iw_ls_wdata = 24'h123456;
      @(negedge clk);
      check("store_gnt", 32'(bus.ow_ls_gnt), 1);
      step(1);
      bus.iw_ls_we = 1'b0;
      @(negedge clk);
      check("load_gnt", 32'(bus.ow_ls_gnt), 1);
      step(1);
      bus.iw_ls_req = 1'b0;
      step(4);

      // Streaming fetch 0x000..0x007.
      run_ports(8, 'h000, 0, 0);
      step(4);

      // Reset one cycle after a fetch grant: that read must never return.
      run_ports(1, 'h040, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("midreset");
      step(1);
      rst = 1'b0;
      step(1);

      // Contention: both ports with three reads each.
      run_ports(3, 'h100, 3, 'h200);
      step(4);

      check("if_queue_drained", q_if.size(), 0);
      check("ls_queue_drained", q_ls.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
